transformation_fsm: RTL and testbench

//   Sequencer for the FM x W transformation stage of the GCN accelerator. Walks every

---
 rtl/transformation_fsm.sv | 122 ++++++++++++
 tb/tb_transformation_fsm.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/transformation_fsm.sv
// Sequencer for the FM x W transformation stage: walks weight columns and feature rows
// column-major, issuing read, scratch-pad capture and FM_WM write strobes.
module transformation_fsm #(
  parameter int FEATURE_ROWS          = 6,
  parameter int WEIGHT_COLS           = 3,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int COUNTER_WEIGHT_WIDTH  = $clog2(WEIGHT_COLS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [COUNTER_WEIGHT_WIDTH-1:0]  weight_count,
  output logic                             enable_weight_cnt,
  output logic                             enable_read,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  read_weight_address,
  output logic [COUNTER_FEATURE_WIDTH-1:0] read_feature_address,
  output logic                             enable_scratch_pad,
  output logic                             enable_write_fm_wm,
  output logic [COUNTER_FEATURE_WIDTH-1:0] fm_wm_row_out,
  output logic [COUNTER_WEIGHT_WIDTH-1:0]  fm_wm_col_out,
  output logic                             done
);

  localparam logic [COUNTER_FEATURE_WIDTH-1:0] ROW_LAST = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS-1);
  localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  COL_LAST = COUNTER_WEIGHT_WIDTH'(WEIGHT_COLS-1);

  typedef enum logic [2:0] {IDLE, READ_W, READ_F, WRITE, DONE} state_t;

  state_t                             state, state_n;
  logic [COUNTER_FEATURE_WIDTH-1:0]   row, row_n;
  logic                               start_q;
  logic                               en_rd_n, sp_n, wr_n, ewc_n, done_n;
  logic [COUNTER_WEIGHT_WIDTH-1:0]    raddr_w_n, col_out_n, wc_adv, wc_eff;
  logic [COUNTER_FEATURE_WIDTH-1:0]   raddr_f_n, row_out_n;

  // Outputs are registered from the next state, so the address presented in READ_W
  // must anticipate the counter step taken on the same edge.
  assign wc_adv = (weight_count == COL_LAST) ? '0 : weight_count + COUNTER_WEIGHT_WIDTH'(1);
  assign wc_eff = enable_weight_cnt ? wc_adv : weight_count;

  always_comb begin
    state_n   = state;
    row_n     = row;
    en_rd_n   = 1'b0;
    sp_n      = 1'b0;
    wr_n      = 1'b0;
    ewc_n     = 1'b0;
    done_n    = 1'b0;
    raddr_w_n = read_weight_address;
    raddr_f_n = read_feature_address;
    row_out_n = fm_wm_row_out;
    col_out_n = fm_wm_col_out;

    case (state)
      IDLE:   if (start_q) state_n = READ_W;
      READ_W: state_n = READ_F;
      READ_F: state_n = WRITE;
      WRITE: begin
        if (row == ROW_LAST) begin
          row_n   = '0;
          state_n = (weight_count == COL_LAST) ? DONE : READ_W;
        end else begin
          row_n   = row + COUNTER_FEATURE_WIDTH'(1);
          state_n = READ_F;
        end
      end
      DONE:   if (!start_q) state_n = IDLE;
      default: state_n = IDLE;
    endcase

    case (state_n)
      READ_W: begin
        en_rd_n   = 1'b1;
        sp_n      = 1'b1;
        raddr_w_n = wc_eff;
      end
      READ_F: begin
        en_rd_n   = 1'b1;
        raddr_f_n = row_n;
      end
      WRITE: begin
        wr_n      = 1'b1;
        row_out_n = row_n;
        col_out_n = weight_count;
        ewc_n     = (row_n == ROW_LAST);
      end
      DONE:    done_n = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                <= IDLE;
      row                  <= '0;
      start_q              <= 1'b0;
      enable_weight_cnt    <= 1'b0;
      enable_read          <= 1'b0;
      read_weight_address  <= '0;
      read_feature_address <= '0;
      enable_scratch_pad   <= 1'b0;
      enable_write_fm_wm   <= 1'b0;
      fm_wm_row_out        <= '0;
      fm_wm_col_out        <= '0;
      done                 <= 1'b0;
    end else begin
      state                <= state_n;
      row                  <= row_n;
      start_q              <= start;
      enable_weight_cnt    <= ewc_n;
      enable_read          <= en_rd_n;
      read_weight_address  <= raddr_w_n;
      read_feature_address <= raddr_f_n;
      enable_scratch_pad   <= sp_n;
      enable_write_fm_wm   <= wr_n;
      fm_wm_row_out        <= row_out_n;
      fm_wm_col_out        <= col_out_n;
      done                 <= done_n;
    end
  end

endmodule

// File: tb/tb_transformation_fsm.sv
// Directed bench for transformation_fsm with a behavioural weight-column counter.
module tb_transformation_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] weight_count;
  logic       enable_weight_cnt, enable_read, enable_scratch_pad, enable_write_fm_wm, done;
  logic [1:0] read_weight_address, fm_wm_col_out;
  logic [2:0] read_feature_address, fm_wm_row_out;

  int vec = 0, err = 0;
  int nwr, newc, nsp, bad_f, viol;
  logic [2:0] wr_row [64];
  logic [1:0] wr_col [64];
  logic [1:0] sp_addr [8];
  logic       prev_rd, prev_sp;
  logic [2:0] prev_faddr;

  transformation_fsm dut (
    .clk(clk), .rst(rst), .start(start), .weight_count(weight_count),
    .enable_weight_cnt(enable_weight_cnt), .enable_read(enable_read),
    .read_weight_address(read_weight_address), .read_feature_address(read_feature_address),
    .enable_scratch_pad(enable_scratch_pad), .enable_write_fm_wm(enable_write_fm_wm),
    .fm_wm_row_out(fm_wm_row_out), .fm_wm_col_out(fm_wm_col_out), .done(done)
  );

  always #5 clk = ~clk;

  // upstream weight-column counter, wraps at 3 columns
  always_ff @(posedge clk or posedge rst)
    if (rst) weight_count <= 2'd0;
    else if (enable_weight_cnt) weight_count <= (weight_count == 2'd2) ? 2'd0 : weight_count + 2'd1;

  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 1'b0; prev_sp = 1'b0; prev_faddr = 3'd0;
    end else begin
      if (enable_write_fm_wm) begin
        if (nwr < 64) begin wr_row[nwr] = fm_wm_row_out; wr_col[nwr] = fm_wm_col_out; end
        if (!(prev_rd && !prev_sp && prev_faddr == fm_wm_row_out)) bad_f++;
        nwr++;
      end
      if (enable_weight_cnt) newc++;
      if (enable_scratch_pad) begin
        if (nsp < 8) sp_addr[nsp] = read_weight_address;
        nsp++;
      end
      if ((enable_scratch_pad && enable_write_fm_wm) || (enable_read && enable_write_fm_wm) ||
          (enable_weight_cnt && !enable_write_fm_wm)) viol++;
      prev_rd = enable_read; prev_sp = enable_scratch_pad; prev_faddr = read_feature_address;
    end
  end

  // Launches a run and returns edges from the start-sampling edge until done is seen.
  // pulse_cyc>0 pulses start again during that cycle of the run.
  task automatic run_pass(input bit hold, input int pulse_cyc, output int cycles);
    bit pulsing = 0;
    @(posedge clk); #1;
    nwr = 0; newc = 0; nsp = 0; bad_f = 0; viol = 0;
    @(negedge clk) start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    cycles = 0;
    while (!done && cycles < 200) begin
      @(posedge clk); #1;
      cycles++;
      if (pulsing) begin start = 1'b0; pulsing = 0; end
      if (pulse_cyc > 0 && cycles == pulse_cyc) begin
        vec++;
        if (!(enable_read && !enable_scratch_pad)) begin
          err++; $display("FAIL pulse_in_read_f: rd=%b sp=%b, required rd=1 sp=0", enable_read, enable_scratch_pad);
        end
        @(negedge clk) start = 1'b1;
        pulsing = 1;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({enable_weight_cnt, enable_read, enable_scratch_pad, enable_write_fm_wm, done} !== 5'b0) begin
      err++; $display("FAIL reset_strobes: got %b, required 00000",
        {enable_weight_cnt, enable_read, enable_scratch_pad, enable_write_fm_wm, done});
    end
    vec++;
    if ({read_weight_address, read_feature_address, fm_wm_row_out, fm_wm_col_out} !== 10'b0) begin
      err++; $display("FAIL reset_addr: got %h, required 0",
        {read_weight_address, read_feature_address, fm_wm_row_out, fm_wm_col_out});
    end
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_full_run;
    int cyc;
    run_pass(0, 0, cyc);
    vec++; if (cyc !== 40) begin err++; $display("FAIL latency: got %0d, required 40", cyc); end
    vec++; if (nwr !== 18) begin err++; $display("FAIL write_count: got %0d, required 18", nwr); end
    vec++; if (newc !== 3) begin err++; $display("FAIL wcnt_pulses: got %0d, required 3", newc); end
    vec++; if (viol !== 0) begin err++; $display("FAIL strobe_exclusive: got %0d overlaps, required 0", viol); end
    vec++; if (weight_count !== 2'd0) begin err++; $display("FAIL counter_wrap: got %0d, required 0", weight_count); end
  endtask

  task automatic test_write_order;
    for (int i = 0; i < 18; i++) begin
      vec++;
      if (wr_row[i] !== 3'(i % 6) || wr_col[i] !== 2'(i / 6)) begin
        err++; $display("FAIL write_order[%0d]: got (%0d,%0d), required (%0d,%0d)", i, wr_row[i], wr_col[i], i % 6, i / 6);
      end
    end
    vec++; if (bad_f !== 0) begin err++; $display("FAIL feature_addr: got %0d bad reads, required 0", bad_f); end
  endtask

  task automatic test_scratch_pad;
    vec++; if (nsp !== 3) begin err++; $display("FAIL sp_count: got %0d, required 3", nsp); end
    for (int i = 0; i < 3; i++) begin
      vec++;
      if (sp_addr[i] !== 2'(i)) begin
        err++; $display("FAIL sp_addr[%0d]: got %0d, required %0d", i, sp_addr[i], i);
      end
    end
  endtask

  task automatic test_hold_start;
    int cyc, w;
    run_pass(1, 0, cyc);
    vec++; if (cyc !== 40) begin err++; $display("FAIL hold_latency: got %0d, required 40", cyc); end
    repeat (6) @(posedge clk);
    #1;
    vec++;
    if (done !== 1'b1 || nwr !== 18 || enable_read !== 1'b0) begin
      err++; $display("FAIL hold_no_restart: done=%b writes=%0d rd=%b, required 1/18/0", done, nwr, enable_read);
    end
    @(negedge clk) start = 1'b0;
    w = 0;
    while (done && w < 10) begin @(posedge clk); #1; w++; end
    vec++; if (done !== 1'b0) begin err++; $display("FAIL done_drop: got %b, required 0", done); end
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if (nwr !== 18 || enable_read !== 1'b0 || enable_scratch_pad !== 1'b0) begin
      err++; $display("FAIL idle_quiet: writes=%0d rd=%b sp=%b, required 18/0/0", nwr, enable_read, enable_scratch_pad);
    end
  endtask

  task automatic test_second_pass;
    int cyc;
    run_pass(0, 0, cyc);
    vec++; if (cyc !== 40) begin err++; $display("FAIL pass2_latency: got %0d, required 40", cyc); end
    vec++; if (nwr !== 18 || newc !== 3) begin err++; $display("FAIL pass2_counts: got %0d/%0d, required 18/3", nwr, newc); end
    for (int i = 0; i < 18; i += 5) begin
      vec++;
      if (wr_row[i] !== 3'(i % 6) || wr_col[i] !== 2'(i / 6)) begin
        err++; $display("FAIL pass2_order[%0d]: got (%0d,%0d), required (%0d,%0d)", i, wr_row[i], wr_col[i], i % 6, i / 6);
      end
    end
    vec++; if (sp_addr[2] !== 2'd2) begin err++; $display("FAIL pass2_sp_addr: got %0d, required 2", sp_addr[2]); end
  endtask

  task automatic test_reset_mid_run;
    int w, cyc;
    @(posedge clk); #1;
    nwr = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    w = 0;
    while (!(enable_write_fm_wm && fm_wm_row_out == 3'd3 && fm_wm_col_out == 2'd1) && w < 100) begin
      @(posedge clk); #1; w++;
    end
    vec++; if (w >= 100) begin err++; $display("FAIL reach_row3_col1: timed out after %0d cycles, required < 100", w); end
    #2 rst = 1'b1;
    #1;
    vec++;
    if ({enable_weight_cnt, enable_read, enable_scratch_pad, enable_write_fm_wm, done,
         read_weight_address, read_feature_address, fm_wm_row_out, fm_wm_col_out} !== 15'b0) begin
      err++; $display("FAIL reset_abort: got %h, required 0", {enable_weight_cnt, enable_read, enable_scratch_pad,
        enable_write_fm_wm, done, read_weight_address, read_feature_address, fm_wm_row_out, fm_wm_col_out});
    end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vec++;
    if ({enable_read, enable_write_fm_wm, done} !== 3'b0) begin
      err++; $display("FAIL idle_after_reset: got %b, required 000", {enable_read, enable_write_fm_wm, done});
    end
    run_pass(0, 0, cyc);
    vec++; if (cyc !== 40) begin err++; $display("FAIL post_reset_latency: got %0d, required 40", cyc); end
    vec++; if (nwr !== 18 || newc !== 3) begin err++; $display("FAIL post_reset_counts: got %0d/%0d, required 18/3", nwr, newc); end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_start_glitch;
    int cyc;
    run_pass(0, 2, cyc);
    vec++; if (cyc !== 40) begin err++; $display("FAIL glitch_latency: got %0d, required 40", cyc); end
    vec++; if (nwr !== 18) begin err++; $display("FAIL glitch_writes: got %0d, required 18", nwr); end
    vec++; if (viol !== 0 || bad_f !== 0) begin err++; $display("FAIL glitch_sequence: got %0d/%0d, required 0/0", viol, bad_f); end
  endtask

  initial begin
    test_reset;
    test_full_run;
    test_write_order;
    test_scratch_pad;
    test_hold_start;
    test_second_pass;
    test_reset_mid_run;
    test_start_glitch;
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
